// File: rtl/wb_pkg.sv
// Shared types and constants for the parametrised Wishbone fan-out interconnect.
package wb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_RESP = ST_RESP
    } wb_state_e;

    // Error cause carried into the response cycle; non-zero drives wbc_err.
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_UNMAPPED = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    function automatic int selw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Up-counter bounding how long the interconnect waits for a peripheral ack.
module wb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Fires in the cycle whose increment brings the count to TIMEOUT.
    assign expired = en && !clr && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_interconnect_n.sv
// One Wishbone controller fanned out to NPERIPH peripherals, single outstanding transaction.
// state  | meaning
// IDLE   | accepting requests; unmapped address answered with err next cycle
// WAIT   | strobe issued, waiting for the selected peripheral's ack or timeout
// RESP   | one-cycle ack (with read data) or err back to the controller
module wb_interconnect_n
    import wb_pkg::*;
#(
    parameter int NPERIPH = 4,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wbc_stb,
    input  logic                          wbc_we,
    input  logic [AW-1:0]                 wbc_adr,
    input  logic [DW-1:0]                 wbc_dat_w,
    output logic [DW-1:0]                 wbc_dat_r,
    output logic                          wbc_ack,
    output logic                          wbc_err,
    output logic                          wbc_stall,
    output logic [NPERIPH-1:0]            wbp_stb,
    output logic                          wbp_we,
    output logic [AW-selw(NPERIPH)-1:0]   wbp_adr,
    output logic [DW-1:0]                 wbp_dat_w,
    input  logic [NPERIPH*DW-1:0]         wbp_dat_r,
    input  logic [NPERIPH-1:0]            wbp_ack
);

    localparam int SELW = selw(NPERIPH);
    localparam int LAW  = AW - SELW;

    wb_state_e           state_q, state_d;
    logic [SELW-1:0]     idx_q, idx_d;
    logic [NPERIPH-1:0]  stb_q, stb_d;
    logic                we_q, we_d;
    logic [LAW-1:0]      adr_q, adr_d;
    logic [DW-1:0]       dat_w_q, dat_w_d;
    logic [DW-1:0]       dat_r_q, dat_r_d;
    logic                ack_q, ack_d;
    logic [1:0]          errc_q, errc_d;

    logic [SELW-1:0]     idx_in;
    logic [NPERIPH-1:0]  hit;
    logic                mapped;
    logic                sel_ack;
    logic [DW-1:0]       sel_dat;
    logic                tmo_clr, tmo_en, tmo_expired;

    assign idx_in = wbc_adr[AW-1 -: SELW];

    always_comb begin
        hit = '0;
        for (int i = 0; i < NPERIPH; i++) begin
            hit[i] = (idx_in == SELW'(i));
        end
    end

    assign mapped = |hit;

    // Only the latched target's ack and data are visible; other ports are ignored.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NPERIPH; i++) begin
            if (idx_q == SELW'(i)) begin
                sel_ack = wbp_ack[i];
                sel_dat = wbp_dat_r[i*DW +: DW];
            end
        end
    end

    assign tmo_clr = (state_q != S_WAIT);
    assign tmo_en  = (state_q == S_WAIT);

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_w_d = dat_w_q;
        stb_d   = '0;
        dat_r_d = '0;
        ack_d   = 1'b0;
        errc_d  = ERR_NONE;
        case (state_q)
            S_IDLE: begin
                if (wbc_stb) begin
                    idx_d   = idx_in;
                    we_d    = wbc_we;
                    adr_d   = wbc_adr[LAW-1:0];
                    dat_w_d = wbc_dat_w;
                    if (mapped) begin
                        stb_d   = hit;
                        state_d = S_WAIT;
                    end else begin
                        errc_d  = ERR_UNMAPPED;
                    end
                end
            end
            S_WAIT: begin
                if (sel_ack) begin
                    dat_r_d = sel_dat;
                    ack_d   = 1'b1;
                    state_d = S_RESP;
                end else if (tmo_expired) begin
                    errc_d  = ERR_TIMEOUT;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            stb_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_w_q <= '0;
            dat_r_q <= '0;
            ack_q   <= 1'b0;
            errc_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_w_q <= dat_w_d;
            dat_r_q <= dat_r_d;
            ack_q   <= ack_d;
            errc_q  <= errc_d;
        end
    end

    assign wbc_dat_r = dat_r_q;
    assign wbc_ack   = ack_q;
    assign wbc_err   = (errc_q != ERR_NONE);
    assign wbc_stall = (state_q != S_IDLE);
    assign wbp_stb   = stb_q;
    assign wbp_we    = we_q;
    assign wbp_adr   = adr_q;
    assign wbp_dat_w = dat_w_q;

endmodule

// File: tb/tb_wb_interconnect_n.sv
// Directed bench: four-port instance for the main scenarios, three-port instance for unmapped decode.
module tb_wb_interconnect_n;

    logic        clk;
    logic        rst_n;
    logic        stb, stb3, we;
    logic [7:0]  adr, dat_w;

    logic [31:0] dat_r4;
    logic [3:0]  ack4;
    logic [7:0]  dr4, pdw4;
    logic        ack_o4, err4, stall4, pwe4;
    logic [3:0]  pstb4;
    logic [5:0]  padr4;

    logic [23:0] dat_r3;
    logic [2:0]  ack3;
    logic [7:0]  dr3, pdw3;
    logic        ack_o3, err3, stall3, pwe3;
    logic [2:0]  pstb3;
    logic [5:0]  padr3;

    int checks;
    int failures;

    wb_interconnect_n #(.NPERIPH(4), .AW(8), .DW(8), .TIMEOUT(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .wbc_stb(stb), .wbc_we(we), .wbc_adr(adr),
        .wbc_dat_w(dat_w), .wbc_dat_r(dr4), .wbc_ack(ack_o4), .wbc_err(err4),
        .wbc_stall(stall4), .wbp_stb(pstb4), .wbp_we(pwe4), .wbp_adr(padr4),
        .wbp_dat_w(pdw4), .wbp_dat_r(dat_r4), .wbp_ack(ack4)
    );

    wb_interconnect_n #(.NPERIPH(3), .AW(8), .DW(8), .TIMEOUT(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .wbc_stb(stb3), .wbc_we(we), .wbc_adr(adr),
        .wbc_dat_w(dat_w), .wbc_dat_r(dr3), .wbc_ack(ack_o3), .wbc_err(err3),
        .wbc_stall(stall3), .wbp_stb(pstb3), .wbp_we(pwe3), .wbp_adr(padr3),
        .wbp_dat_w(pdw3), .wbp_dat_r(dat_r3), .wbp_ack(ack3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({dr4, ack_o4, err4, stall4, pstb4, pwe4, padr4, pdw4} !== 30'd0) begin
            failures++;
            $display("FAIL reset_outs4 got=%0h exp=0", {dr4, ack_o4, err4, stall4, pstb4, pwe4, padr4, pdw4});
        end
        checks++;
        if ({dr3, ack_o3, err3, stall3, pstb3, pwe3, padr3, pdw3} !== 29'd0) begin
            failures++;
            $display("FAIL reset_outs3 got=%0h exp=0", {dr3, ack_o3, err3, stall3, pstb3, pwe3, padr3, pdw3});
        end
    endtask

    task automatic test_write();
        stb = 1'b1; we = 1'b1; adr = 8'h85; dat_w = 8'h3C;
        tick();
        stb = 1'b0; ack4 = 4'b0100;
        checks++;
        if (pstb4 !== 4'b0100) begin failures++; $display("FAIL wr_pstb got=%b exp=0100", pstb4); end
        checks++;
        if ({pwe4, padr4, pdw4} !== {1'b1, 6'h05, 8'h3C}) begin
            failures++; $display("FAIL wr_bus got=%0h exp=%0h", {pwe4, padr4, pdw4}, {1'b1, 6'h05, 8'h3C});
        end
        checks++;
        if ({stall4, ack_o4} !== 2'b10) begin failures++; $display("FAIL wr_c1_stall_ack got=%b exp=10", {stall4, ack_o4}); end
        tick();
        ack4 = 4'b0000;
        checks++;
        if ({ack_o4, err4, pstb4} !== 6'b10_0000) begin
            failures++; $display("FAIL wr_c2_ack got=%b exp=100000", {ack_o4, err4, pstb4});
        end
        tick();
        checks++;
        if ({ack_o4, err4, stall4} !== 3'b000) begin failures++; $display("FAIL wr_c3_idle got=%b exp=000", {ack_o4, err4, stall4}); end
    endtask

    task automatic test_read();
        int stall_cycles;
        stb = 1'b1; we = 1'b0; adr = 8'hC1; dat_w = 8'h11;
        tick();
        stb = 1'b0;
        checks++;
        if ({pstb4, pwe4, padr4} !== {4'b1000, 1'b0, 6'h01}) begin
            failures++; $display("FAIL rd_pstb_bus got=%0h exp=%0h", {pstb4, pwe4, padr4}, {4'b1000, 1'b0, 6'h01});
        end
        stall_cycles = 0;
        for (int c = 1; c <= 4; c++) begin
            if (stall4 === 1'b1 && ack_o4 === 1'b0) stall_cycles++;
            if (c == 4) begin ack4 = 4'b1000; dat_r4 = 32'hA5_00_00_00; end
            tick();
        end
        ack4 = 4'b0000; dat_r4 = 32'h0;
        checks++;
        if (stall_cycles !== 4) begin failures++; $display("FAIL rd_stall_cycles got=%0d exp=4", stall_cycles); end
        checks++;
        if ({ack_o4, err4, dr4} !== {2'b10, 8'hA5}) begin
            failures++; $display("FAIL rd_c5_ack_data got=%0h exp=%0h", {ack_o4, err4, dr4}, {2'b10, 8'hA5});
        end
        tick();
        checks++;
        if ({ack_o4, dr4} !== 9'h000) begin failures++; $display("FAIL rd_c6_data_clear got=%0h exp=0", {ack_o4, dr4}); end
        checks++;
        if ({pwe4, padr4, pdw4} !== {1'b0, 6'h01, 8'h11}) begin
            failures++; $display("FAIL rd_bus_hold got=%0h exp=%0h", {pwe4, padr4, pdw4}, {1'b0, 6'h01, 8'h11});
        end
    endtask

    task automatic test_unmapped();
        stb3 = 1'b1; we = 1'b1; adr = 8'hC0; dat_w = 8'h99;
        tick();
        stb3 = 1'b0;
        checks++;
        if ({err3, ack_o3, stall3, pstb3} !== 6'b100_000) begin
            failures++; $display("FAIL unm_c1 got=%b exp=100000", {err3, ack_o3, stall3, pstb3});
        end
        tick();
        checks++;
        if ({err3, stall3, pstb3} !== 5'b0) begin failures++; $display("FAIL unm_c2 got=%b exp=00000", {err3, stall3, pstb3}); end
    endtask

    task automatic test_timeout();
        int n;
        bit found;
        stb = 1'b1; we = 1'b1; adr = 8'h02; dat_w = 8'h5E;
        tick();
        stb = 1'b0;
        n = 1; found = 1'b0;
        while (n <= 20 && !found) begin
            if (err4 === 1'b1) found = 1'b1;
            else begin tick(); n++; end
        end
        checks++;
        if (!found || n != 9) begin failures++; $display("FAIL tmo_err_cycle got=%0d exp=9 found=%0d", n, found); end
        checks++;
        if ({ack_o4, dr4} !== 9'h000) begin failures++; $display("FAIL tmo_no_ack got=%0h exp=0", {ack_o4, dr4}); end
        tick();
        checks++;
        if ({err4, stall4} !== 2'b00) begin failures++; $display("FAIL tmo_after got=%b exp=00", {err4, stall4}); end
        tick();
        ack4 = 4'b0001; dat_r4 = 32'h0000_00EE;
        tick();
        ack4 = 4'b0000; dat_r4 = 32'h0;
        checks++;
        if ({ack_o4, err4, stall4, dr4} !== 11'h000) begin
            failures++; $display("FAIL tmo_late_ack got=%0h exp=0", {ack_o4, err4, stall4, dr4});
        end
    endtask

    task automatic test_wrong_ack();
        stb = 1'b1; we = 1'b0; adr = 8'h41; dat_w = 8'h00;
        tick();
        stb = 1'b0;
        checks++;
        if (pstb4 !== 4'b0010) begin failures++; $display("FAIL wa_pstb got=%b exp=0010", pstb4); end
        tick();
        ack4 = 4'b0001; dat_r4 = 32'h0000_00DD; stb = 1'b1; adr = 8'h80;
        tick();
        ack4 = 4'b0000; stb = 1'b0;
        checks++;
        if ({stall4, ack_o4, err4, pstb4, padr4} !== {3'b100, 4'b0000, 6'h01}) begin
            failures++; $display("FAIL wa_ignored got=%0h exp=%0h", {stall4, ack_o4, err4, pstb4, padr4}, {3'b100, 4'b0000, 6'h01});
        end
        for (int c = 3; c < 8; c++) tick();
        ack4 = 4'b0010; dat_r4 = 32'h0000_4200;
        tick();
        ack4 = 4'b0000; dat_r4 = 32'h0;
        checks++;
        if ({ack_o4, err4, dr4} !== {2'b10, 8'h42}) begin
            failures++; $display("FAIL wa_ack_wins got=%0h exp=%0h", {ack_o4, err4, dr4}, {2'b10, 8'h42});
        end
        tick();
        checks++;
        if ({ack_o4, err4, stall4} !== 3'b000) begin failures++; $display("FAIL wa_after got=%b exp=000", {ack_o4, err4, stall4}); end
    endtask

    task automatic test_async_reset();
        stb = 1'b1; we = 1'b1; adr = 8'h85; dat_w = 8'h77;
        tick();
        stb = 1'b0;
        checks++;
        if (pstb4 !== 4'b0100) begin failures++; $display("FAIL ar_pstb got=%b exp=0100", pstb4); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dr4, ack_o4, err4, stall4, pstb4, pwe4, padr4, pdw4} !== 30'd0) begin
            failures++; $display("FAIL ar_outs got=%0h exp=0", {dr4, ack_o4, err4, stall4, pstb4, pwe4, padr4, pdw4});
        end
        #2;
        rst_n = 1'b1;
        tick();
        stb = 1'b1; we = 1'b0; adr = 8'h03;
        tick();
        stb = 1'b0;
        checks++;
        if ({pstb4, padr4} !== {4'b0001, 6'h03}) begin
            failures++; $display("FAIL ar_new_pstb got=%0h exp=%0h", {pstb4, padr4}, {4'b0001, 6'h03});
        end
        ack4 = 4'b0001; dat_r4 = 32'h0000_005A;
        tick();
        ack4 = 4'b0000; dat_r4 = 32'h0;
        checks++;
        if ({ack_o4, err4, dr4} !== {2'b10, 8'h5A}) begin
            failures++; $display("FAIL ar_new_ack got=%0h exp=%0h", {ack_o4, err4, dr4}, {2'b10, 8'h5A});
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; stb = 1'b0; stb3 = 1'b0; we = 1'b0; adr = 8'h00; dat_w = 8'h00;
        dat_r4 = 32'h0; ack4 = 4'b0; dat_r3 = 24'h0; ack3 = 3'b0;
        #12;
        test_reset();
        #5;
        rst_n = 1'b1;
        tick();
        test_write();
        tick();
        test_read();
        tick();
        test_unmapped();
        tick();
        test_timeout();
        tick();
        test_wrong_ack();
        tick();
        test_async_reset();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
